// File: rtl/dsp_reg_bridge_if.sv
// rtl/dsp_reg_bridge_if.sv - SPI-slave transaction and EEPROM handshake bundle for dsp_reg_bridge
interface dsp_reg_bridge_if;
    logic        cs;
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  data_w;
    logic        rdy;
    logic        wr_event_cng;
    logic [7:0]  data_r;
    logic        ee_req;
    logic        ee_we;
    logic [15:0] ee_addr;
    logic [7:0]  ee_wdata;
    logic        ee_ack;
    logic [7:0]  ee_rdata;
    logic        ee_err;

    modport slave (
        input  cs, rw, addr, data_w, rdy, wr_event_cng, ee_ack, ee_rdata, ee_err,
        output data_r, ee_req, ee_we, ee_addr, ee_wdata
    );

    modport master (
        output cs, rw, addr, data_w, rdy, wr_event_cng, ee_ack, ee_rdata, ee_err,
        input  data_r, ee_req, ee_we, ee_addr, ee_wdata
    );
endinterface

// File: rtl/dsp_reg_bridge.sv
// rtl/dsp_reg_bridge.sv - clk-domain register bank behind the DSP SPI slave with EEPROM request/ack
module dsp_reg_bridge #(
    parameter logic [7:0] ID_VAL      = 8'hA5,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          TO_W        = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    dsp_reg_bridge_if.slave  bus
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_n;

    logic [1:0] wr_sync, rdy_sync, cs_sync;
    logic       wr_q, rdy_q;
    logic       wr_stb, rd_stb, go;
    logic       start, fin_ack, fin_to;

    logic            op, done, err, tmo;
    logic [7:0]      addr_h, addr_l, wdata, rdata, scratch;
    logic [7:0]      data_r_q, rd_mux;
    logic            ee_we_q;
    logic [15:0]     ee_addr_q;
    logic [7:0]      ee_wdata_q;
    logic [TO_W-1:0] cnt;
    logic            unused_rw;

    // Frame direction is implied by which event fires; rw carries no extra meaning here.
    assign unused_rw = bus.rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync  <= '0;
            rdy_sync <= '0;
            cs_sync  <= '0;
            wr_q     <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            wr_sync  <= {wr_sync[0], bus.wr_event_cng};
            rdy_sync <= {rdy_sync[0], bus.rdy};
            cs_sync  <= {cs_sync[0], bus.cs};
            wr_q     <= wr_sync[1];
            rdy_q    <= rdy_sync[1];
        end
    end

    // addr/data_w are held by the slave long enough to be sampled without synchronising.
    assign wr_stb = wr_sync[1] & ~wr_q & ~cs_sync[1];
    assign rd_stb = rdy_sync[1] & ~rdy_q & ~cs_sync[1];
    assign go     = wr_stb && (bus.addr == 8'h01) && bus.data_w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        fin_ack = 1'b0;
        fin_to  = 1'b0;
        case (state)
            IDLE: if (go) begin
                state_n = REQ;
                start   = 1'b1;
            end
            REQ: if (bus.ee_ack) begin
                state_n = IDLE;
                fin_ack = 1'b1;
            end else if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                state_n = IDLE;
                fin_to  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= 1'b0; done <= 1'b0; err <= 1'b0; tmo <= 1'b0;
            addr_h <= '0; addr_l <= '0; wdata <= '0; rdata <= '0; scratch <= '0;
            ee_we_q <= 1'b0; ee_addr_q <= '0; ee_wdata_q <= '0; cnt <= '0;
        end else begin
            if (wr_stb && bus.addr[7:4] == 4'h0) begin
                case (bus.addr[3:0])
                    // A GO arriving while busy must leave OP untouched as well.
                    4'h1: if (!bus.data_w[0] || state == IDLE) op <= bus.data_w[1];
                    4'h3: addr_h  <= bus.data_w;
                    4'h4: addr_l  <= bus.data_w;
                    4'h5: wdata   <= bus.data_w;
                    4'h7: scratch <= bus.data_w;
                    default: ;
                endcase
            end
            if (start) begin
                done       <= 1'b0;
                err        <= 1'b0;
                tmo        <= 1'b0;
                ee_addr_q  <= {addr_h, addr_l};
                ee_wdata_q <= wdata;
                ee_we_q    <= bus.data_w[1];
                cnt        <= '0;
            end
            if (state == REQ && !fin_ack && !fin_to) cnt <= cnt + 1'b1;
            if (fin_ack) begin
                if (!ee_we_q) rdata <= bus.ee_rdata;
                err  <= bus.ee_err;
                done <= 1'b1;
            end
            if (fin_to) begin
                tmo  <= 1'b1;
                err  <= 1'b1;
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (bus.addr[7:4] == 4'h0) begin
            case (bus.addr[3:0])
                4'h0: rd_mux = ID_VAL;
                4'h1: rd_mux = {6'b0, op, 1'b0};
                4'h2: rd_mux = {4'b0, tmo, err, done, state == REQ};
                4'h3: rd_mux = addr_h;
                4'h4: rd_mux = addr_l;
                4'h5: rd_mux = wdata;
                4'h6: rd_mux = rdata;
                4'h7: rd_mux = scratch;
                default: rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_r_q <= '0;
        else if (rd_stb) data_r_q <= rd_mux;
    end

    assign bus.data_r   = data_r_q;
    assign bus.ee_req   = (state == REQ);
    assign bus.ee_we    = ee_we_q;
    assign bus.ee_addr  = ee_addr_q;
    assign bus.ee_wdata = ee_wdata_q;
endmodule

// File: tb/tb_dsp_reg_bridge.sv
// tb/tb_dsp_reg_bridge.sv - self-checking bench for dsp_reg_bridge
module tb_dsp_reg_bridge;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsp_reg_bridge_if bus();
    dsp_reg_bridge dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    int pcyc = 0;
    int rise_c = -1;
    int fall_c = -1;
    int n_rise = 0;
    logic req_prev = 1'b0;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (bus.ee_req === 1'b1 && !req_prev) begin
            rise_c = pcyc;
            n_rise++;
        end
        if (bus.ee_req !== 1'b1 && req_prev) fall_c = pcyc;
        req_prev = (bus.ee_req === 1'b1);
    end

    // Reference model of the register map
    logic       m_op, m_busy, m_done, m_err, m_tmo;
    logic [7:0] m_ah, m_al, m_wd, m_rd, m_sc;

    task automatic m_reset();
        m_op = 0; m_busy = 0; m_done = 0; m_err = 0; m_tmo = 0;
        m_ah = 0; m_al = 0; m_wd = 0; m_rd = 0; m_sc = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a[7:4] != 0) return 8'h00;
        case (a[3:0])
            4'h0: return 8'hA5;
            4'h1: return {6'b0, m_op, 1'b0};
            4'h2: return {4'b0, m_tmo, m_err, m_done, m_busy};
            4'h3: return m_ah;
            4'h4: return m_al;
            4'h5: return m_wd;
            4'h6: return m_rd;
            4'h7: return m_sc;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (a[7:4] != 0) return;
        case (a[3:0])
            4'h1: if (!d[0]) m_op = d[1];
                  else if (!m_busy) begin
                      m_op = d[1]; m_busy = 1; m_done = 0; m_err = 0; m_tmo = 0;
                  end
            4'h3: m_ah = d;
            4'h4: m_al = d;
            4'h5: m_wd = d;
            4'h7: m_sc = d;
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [7:0] d, input bit cs_hi = 0);
        @(negedge clk);
        bus.cs = cs_hi; bus.rw = 1'b0; bus.addr = a; bus.data_w = d;
        repeat (4) @(negedge clk);
        bus.wr_event_cng = 1'b1;
        repeat (6) @(negedge clk);
        bus.wr_event_cng = 1'b0;
        bus.cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_read(input logic [7:0] a, output logic [7:0] v, input bit cs_hi = 0);
        @(negedge clk);
        bus.cs = cs_hi; bus.rw = 1'b1; bus.addr = a;
        repeat (4) @(negedge clk);
        bus.rdy = 1'b1;
        repeat (6) @(negedge clk);
        v = bus.data_r;
        bus.rdy = 1'b0;
        bus.cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_ack(input logic [7:0] rd, input bit er);
        @(negedge clk);
        bus.ee_ack = 1'b1; bus.ee_rdata = rd; bus.ee_err = er;
        @(negedge clk);
        bus.ee_ack = 1'b0; bus.ee_err = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit         wr;
        bit         cs_hi;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [7:0] v, a, d;
        int n0;

        tbl[0]  = '{0, 0, 8'h00, 8'h00, 8'hA5};
        tbl[1]  = '{0, 0, 8'h07, 8'h00, 8'h00};
        tbl[2]  = '{0, 0, 8'h85, 8'h00, 8'h00};
        tbl[3]  = '{1, 0, 8'h07, 8'h3C, 8'h00};
        tbl[4]  = '{0, 0, 8'h07, 8'h00, 8'h3C};
        tbl[5]  = '{1, 0, 8'h00, 8'h55, 8'h00};
        tbl[6]  = '{0, 0, 8'h00, 8'h00, 8'hA5};
        tbl[7]  = '{1, 0, 8'h83, 8'h77, 8'h00};
        tbl[8]  = '{0, 0, 8'h03, 8'h00, 8'h00};
        tbl[9]  = '{1, 0, 8'h06, 8'hFF, 8'h00};
        tbl[10] = '{0, 0, 8'h06, 8'h00, 8'h00};
        tbl[11] = '{0, 1, 8'h00, 8'h00, 8'h00};
        tbl[12] = '{1, 1, 8'h07, 8'hAA, 8'h00};
        tbl[13] = '{0, 0, 8'h07, 8'h00, 8'h3C};
        tbl[14] = '{1, 0, 8'h01, 8'h02, 8'h00};
        tbl[15] = '{0, 0, 8'h01, 8'h00, 8'h02};
        tbl[16] = '{1, 0, 8'h01, 8'h00, 8'h00};
        tbl[17] = '{0, 0, 8'h02, 8'h00, 8'h00};
        tbl[18] = '{0, 0, 8'h08, 8'h00, 8'h00};

        bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = '0; bus.data_w = '0;
        bus.rdy = 1'b0; bus.wr_event_cng = 1'b0;
        bus.ee_ack = 1'b0; bus.ee_rdata = '0; bus.ee_err = 1'b0;
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_data_r", bus.data_r, 8'h00);
        check("reset_ee_req", bus.ee_req, 1'b0);
        check("reset_ee_we", bus.ee_we, 1'b0);
        check("reset_ee_addr", bus.ee_addr, 16'h0000);
        check("reset_ee_wdata", bus.ee_wdata, 8'h00);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) begin
                spi_write(tbl[i].a, tbl[i].d, tbl[i].cs_hi);
                if (!tbl[i].cs_hi) m_write(tbl[i].a, tbl[i].d);
            end else begin
                spi_read(tbl[i].a, v, tbl[i].cs_hi);
                check($sformatf("table_%0d_read_%02h", i, tbl[i].a), v, tbl[i].exp);
            end
        end

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 8)       a = 8'(r);
            else if (r == 8) a = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 7))};
            else             a = 8'h0F;
            d = 8'($urandom);
            if (a == 8'h01) d[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                spi_write(a, d);
                m_write(a, d);
            end else begin
                spi_read(a, v);
                check($sformatf("rand_%0d_read_%02h", i, a), v, m_read(a));
            end
        end
        check("rand_no_request", n_rise, 0);

        // EEPROM write
        spi_write(8'h03, 8'h12);
        spi_write(8'h04, 8'h34);
        spi_write(8'h05, 8'h99);
        spi_write(8'h01, 8'h03);
        check("wr_ee_req", bus.ee_req, 1'b1);
        check("wr_ee_we", bus.ee_we, 1'b1);
        check("wr_ee_addr", bus.ee_addr, 16'h1234);
        check("wr_ee_wdata", bus.ee_wdata, 8'h99);
        repeat (20) @(negedge clk);
        do_ack(8'hEE, 1'b0);
        check("wr_ack_req_low", bus.ee_req, 1'b0);
        spi_read(8'h02, v); check("wr_status", v, 8'h02);
        spi_read(8'h01, v); check("wr_ctrl_go_clear", v, 8'h02);
        spi_read(8'h06, v); check("wr_rdata_untouched", v, 8'h00);

        // EEPROM read, no error then with error
        spi_write(8'h01, 8'h01);
        check("rd_ee_we", bus.ee_we, 1'b0);
        spi_read(8'h02, v); check("rd_status_busy", v, 8'h01);
        spi_read(8'h06, v); check("rd_rdata_during_busy", v, 8'h00);
        do_ack(8'h6B, 1'b0);
        spi_read(8'h06, v); check("rd_rdata", v, 8'h6B);
        spi_read(8'h02, v); check("rd_status", v, 8'h02);
        spi_write(8'h01, 8'h01);
        do_ack(8'hC3, 1'b1);
        spi_read(8'h02, v); check("rd_err_status", v, 8'h06);
        spi_read(8'h06, v); check("rd_err_rdata", v, 8'hC3);

        // Timeout
        rise_c = -1; fall_c = -1;
        spi_write(8'h01, 8'h01);
        check("to_req_high", bus.ee_req, 1'b1);
        for (int i = 0; i < 1500 && fall_c < 0; i++) @(negedge clk);
        check("to_req_dropped", fall_c >= 0, 1'b1);
        check("to_req_width", fall_c - rise_c, 1024);
        spi_read(8'h02, v); check("to_status", v, 8'h0E);

        // Ack on the last cycle before timeout
        rise_c = -1;
        spi_write(8'h01, 8'h01);
        check("race_req_seen", rise_c >= 0, 1'b1);
        for (int i = 0; i < 1100 && pcyc < rise_c + 1023; i++) @(negedge clk);
        bus.ee_ack = 1'b1; bus.ee_rdata = 8'h5A; bus.ee_err = 1'b0;
        @(negedge clk);
        bus.ee_ack = 1'b0;
        @(negedge clk);
        check("race_req_low", bus.ee_req, 1'b0);
        spi_read(8'h02, v); check("race_status", v, 8'h02);
        spi_read(8'h06, v); check("race_rdata", v, 8'h5A);

        // Second GO while busy
        spi_write(8'h03, 8'hAB);
        spi_write(8'h04, 8'hCD);
        n0 = n_rise;
        spi_write(8'h01, 8'h01);
        check("go2_first_addr", bus.ee_addr, 16'hABCD);
        spi_write(8'h04, 8'hEF);
        spi_write(8'h01, 8'h03);
        check("go2_addr_kept", bus.ee_addr, 16'hABCD);
        check("go2_we_kept", bus.ee_we, 1'b0);
        spi_read(8'h01, v); check("go2_op_kept", v, 8'h00);
        spi_read(8'h02, v); check("go2_status_busy", v, 8'h01);
        do_ack(8'h77, 1'b0);
        check("go2_req_low", bus.ee_req, 1'b0);
        repeat (10) @(negedge clk);
        check("go2_single_req", n_rise - n0, 1);
        spi_read(8'h02, v); check("go2_status", v, 8'h02);

        // Reset in the middle of a request
        spi_write(8'h01, 8'h01);
        check("rst_req_high", bus.ee_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_req_async", bus.ee_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        spi_read(8'h02, v); check("rst_status", v, 8'h00);
        spi_read(8'h04, v); check("rst_addr_l", v, 8'h00);
        spi_read(8'h07, v); check("rst_scratch", v, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
